enc164_queue: RTL and testbench

//  Sequential 16-to-4 encoder: the return path for dec416-style one-hot

---
 rtl/enc164_queue.sv | 93 +++++++++
 tb/tb_enc164_queue.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc164_queue.sv
// rtl/enc164_queue.sv - sequential 16-to-4 encoder: latches request lines, issues lowest index per handshake
module enc164_queue #(
    parameter int N_IN  = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  in,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_IN-1:0]  pending,
    output logic [IDX_W:0]   count,
    output logic             overflow
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [N_IN-1:0]  pending_q, pending_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [N_IN-1:0]  avail;
    logic [IDX_W-1:0] low_idx;
    logic             load;

    assign avail = pending_q | in;
    assign load  = (state_q == S_IDLE) || out_ready;

    // Scan from the top so the lowest set bit is the last assignment.
    always_comb begin
        low_idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (avail[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        out_idx_d  = out_idx_q;
        pending_d  = avail;
        overflow_d = |(in & pending_q);
        if (load) begin
            if (avail != '0) begin
                out_idx_d          = low_idx;
                pending_d          = avail;
                pending_d[low_idx] = 1'b0;
                state_d            = S_HOLD;
            end else begin
                pending_d = '0;
                state_d   = S_IDLE;
            end
        end
    end

    // Count tracks the next pending value so it never lags pending.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < N_IN; i++) begin
            count_d = count_d + {{IDX_W{1'b0}}, pending_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            out_idx_q  <= '0;
            pending_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_idx_q  <= out_idx_d;
            pending_q  <= pending_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_idx   = out_idx_q;
    assign out_valid = (state_q == S_HOLD);
    assign pending   = pending_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_enc164_queue.sv
// tb/tb_enc164_queue.sv - scoreboard bench for enc164_queue
module tb_enc164_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_r = '0;
    logic        out_ready = 1'b0;
    logic [3:0]  out_idx;
    logic        out_valid;
    logic [15:0] pending;
    logic [4:0]  count;
    logic        overflow;

    typedef struct packed {
        logic [3:0] idx;
        logic [4:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    enc164_queue dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_r),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        n_vec++;
        if ({out_valid, out_idx, pending, count, overflow} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b i=%0d p=%h c=%0d o=%b want all 0",
                     out_valid, out_idx, pending, count, overflow);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_r = 16'h00F0;
        @(negedge clk);
        in_r = 16'h0020;
        @(negedge clk);
        n_vec++;
        if (overflow !== 1'b1 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL async_setup: got o=%b v=%b want o=1 v=1", overflow, out_valid);
        end
        in_r = 16'h0000;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, out_idx, pending, count, overflow} !== 27'd0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b i=%0d p=%h c=%0d o=%b want all 0",
                     out_valid, out_idx, pending, count, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || pending !== 16'h0) begin
            n_err++;
            $display("FAIL after_reset_idle: got v=%b p=%h want v=0 p=0", out_valid, pending);
        end
    endtask

    task automatic test_single();
        exp_t e;
        @(negedge clk);
        out_ready = 1'b1;
        in_r = 16'h0020;
        sb.push_back('{idx: 4'd5, cnt: 5'd0});
        @(negedge clk);
        in_r = 16'h0;
        e = sb.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || out_idx !== e.idx || count !== e.cnt || pending !== 16'h0) begin
            n_err++;
            $display("FAIL single: got v=%b i=%0d c=%0d p=%h want v=1 i=%0d c=%0d p=0",
                     out_valid, out_idx, count, pending, e.idx, e.cnt);
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_empty: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   done = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_r = 16'h8421;
        sb.push_back('{idx: 4'd0,  cnt: 5'd3});
        sb.push_back('{idx: 4'd5,  cnt: 5'd2});
        sb.push_back('{idx: 4'd10, cnt: 5'd1});
        sb.push_back('{idx: 4'd15, cnt: 5'd0});
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            in_r = 16'h0;
            if (!out_valid) begin
                done = 1;
            end else begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra: got i=%0d want no more output", out_idx);
                end else begin
                    e = sb.pop_front();
                    if (out_idx !== e.idx || count !== e.cnt) begin
                        n_err++;
                        $display("FAIL b2b_issue: got i=%0d c=%0d want i=%0d c=%0d",
                                 out_idx, count, e.idx, e.cnt);
                    end
                end
            end
        end
        n_vec++;
        if (!done || sb.size() != 0) begin
            n_err++;
            $display("FAIL b2b_drain: got done=%0d left=%0d want done=1 left=0", done, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_stall();
        exp_t e;
        @(negedge clk);
        out_ready = 1'b0;
        in_r = 16'h0006;
        sb.push_back('{idx: 4'd1, cnt: 5'd1});
        sb.push_back('{idx: 4'd2, cnt: 5'd0});
        @(negedge clk);
        in_r = 16'h0;
        e = sb.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || out_idx !== e.idx || pending !== 16'h0004 || count !== e.cnt) begin
            n_err++;
            $display("FAIL stall_first: got v=%b i=%0d p=%h c=%0d want v=1 i=%0d p=0004 c=%0d",
                     out_valid, out_idx, pending, count, e.idx, e.cnt);
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || out_idx !== 4'd1 || pending !== 16'h0004) begin
            n_err++;
            $display("FAIL stall_hold: got v=%b i=%0d p=%h want v=1 i=1 p=0004",
                     out_valid, out_idx, pending);
        end
        out_ready = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || out_idx !== e.idx || count !== e.cnt || pending !== 16'h0) begin
            n_err++;
            $display("FAIL stall_release: got v=%b i=%0d c=%0d p=%h want v=1 i=%0d c=%0d p=0",
                     out_valid, out_idx, count, pending, e.idx, e.cnt);
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_empty: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_duplicate();
        exp_t e;
        @(negedge clk);
        out_ready = 1'b0;
        in_r = 16'h0006;
        @(negedge clk);
        n_vec++;
        if (overflow !== 1'b0 || out_idx !== 4'd1 || pending !== 16'h0004) begin
            n_err++;
            $display("FAIL dup_setup: got o=%b i=%0d p=%h want o=0 i=1 p=0004",
                     overflow, out_idx, pending);
        end
        sb.push_back('{idx: 4'd1, cnt: 5'd1});
        sb.push_back('{idx: 4'd2, cnt: 5'd0});
        @(negedge clk);
        in_r = 16'h0;
        n_vec++;
        if (overflow !== 1'b1 || pending !== 16'h0006 || count !== 5'd2 || out_idx !== 4'd1) begin
            n_err++;
            $display("FAIL dup_overflow: got o=%b p=%h c=%0d i=%0d want o=1 p=0006 c=2 i=1",
                     overflow, pending, count, out_idx);
        end
        out_ready = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (overflow !== 1'b0 || out_idx !== e.idx || count !== e.cnt || pending !== 16'h0004) begin
            n_err++;
            $display("FAIL dup_reissue: got o=%b i=%0d c=%0d p=%h want o=0 i=%0d c=%0d p=0004",
                     overflow, out_idx, count, pending, e.idx, e.cnt);
        end
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || out_idx !== e.idx || count !== e.cnt) begin
            n_err++;
            $display("FAIL dup_last: got v=%b i=%0d c=%0d want v=1 i=%0d c=%0d",
                     out_valid, out_idx, count, e.idx, e.cnt);
        end
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL dup_empty: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_full();
        exp_t e;
        int   issued = 0;
        bit   done = 0;
        for (int k = 0; k < 16; k++) begin
            sb.push_back('{idx: 4'(k), cnt: (k == 0) ? 5'd15 : 5'(15 - k)});
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_r = 16'hFFFF;
        @(negedge clk);
        n_vec++;
        if (out_idx !== 4'd0 || count !== 5'd15 || pending !== 16'hFFFE || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_load: got i=%0d c=%0d p=%h o=%b want i=0 c=15 p=fffe o=0",
                     out_idx, count, pending, overflow);
        end
        in_r = 16'hFFFE;
        @(negedge clk);
        n_vec++;
        if (overflow !== 1'b1 || count !== 5'd15 || out_idx !== 4'd0) begin
            n_err++;
            $display("FAIL full_overflow: got o=%b c=%0d i=%0d want o=1 c=15 i=0",
                     overflow, count, out_idx);
        end
        in_r = 16'h0;
        e = sb.pop_front();
        issued = 1;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!out_valid) begin
                done = 1;
            end else begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL full_extra: got i=%0d want no more output", out_idx);
                end else begin
                    e = sb.pop_front();
                    issued++;
                    if (out_idx !== e.idx || count !== e.cnt) begin
                        n_err++;
                        $display("FAIL full_drain: got i=%0d c=%0d want i=%0d c=%0d",
                                 out_idx, count, e.idx, e.cnt);
                    end
                end
            end
        end
        n_vec++;
        if (!done || issued != 16 || pending !== 16'h0) begin
            n_err++;
            $display("FAIL full_total: got done=%0d issued=%0d p=%h want done=1 issued=16 p=0",
                     done, issued, pending);
        end
        sb.delete();
    endtask

    initial begin
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_async_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_duplicate();
        test_full();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
